// File: rtl/fb_wr_sched.sv
// fb_wr_sched: write-port scheduler for the YUV422 framebuffer BRAM.
//
// Shares the single BRAM write port between two valid/ready requesters
// (A: host pixel writer, B: secondary writer) with round-robin arbitration,
// and contains a fill engine that writes a constant word to every line.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   a_valid_i/a_addr_i/a_data_i, a_ready_o   requester A handshake
//   b_valid_i/b_addr_i/b_data_i, b_ready_o   requester B handshake
//   fill_start_i, fill_data_i                fill request and fill word
//   fill_busy_o, fill_done_o                 fill status (done is a 1-cycle pulse)
//   wr_addr_o, wr_d_o, wr_en_o               registered BRAM write port
module fb_wr_sched #(
    parameter int LINES = 16,
    parameter int DW    = 32,
    localparam int AW   = $clog2(LINES)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          a_valid_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_data_i,
    output logic          a_ready_o,
    input  logic          b_valid_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [DW-1:0] b_data_i,
    output logic          b_ready_o,
    input  logic          fill_start_i,
    input  logic [DW-1:0] fill_data_i,
    output logic          fill_busy_o,
    output logic          fill_done_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [DW-1:0] wr_d_o,
    output logic          wr_en_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(LINES - 1);

    typedef enum logic {ST_ARB, ST_FILL} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_last_b;      // 1: B was granted most recently
    logic          w_grant_a;
    logic          w_grant_b;
    logic          w_fill_go;
    logic          w_fill_last;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_d;
    logic          r_wr_en;
    logic          r_busy;
    logic          r_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_a   = 1'b0;
        w_grant_b   = 1'b0;
        w_fill_go   = 1'b0;
        w_fill_last = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (fill_start_i) begin
                    w_fill_go   = 1'b1;
                    w_state_nxt = ST_FILL;
                end else if (a_valid_i && (!b_valid_i || r_last_b)) begin
                    w_grant_a = 1'b1;
                end else if (b_valid_i) begin
                    w_grant_b = 1'b1;
                end
            end
            ST_FILL: begin
                // wr_addr_o doubles as the fill counter: it holds the address
                // currently being written, so it never passes LINES-1.
                if (r_wr_addr == LAST_ADDR) begin
                    w_fill_last = 1'b1;
                    w_state_nxt = ST_ARB;
                end
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    assign a_ready_o = w_grant_a;
    assign b_ready_o = w_grant_b;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last_b  <= 1'b1;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_d    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_fill_last;
            if (w_fill_go) begin
                // wr_d_o captures the fill word here and is left untouched
                // for the rest of the fill.
                r_wr_en   <= 1'b1;
                r_wr_addr <= '0;
                r_wr_d    <= fill_data_i;
                r_busy    <= 1'b1;
            end else if (r_state == ST_FILL) begin
                if (w_fill_last) begin
                    r_wr_en <= 1'b0;
                    r_busy  <= 1'b0;
                end else begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_wr_addr + AW'(1);
                end
            end else if (w_grant_a) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= a_addr_i;
                r_wr_d    <= a_data_i;
                r_last_b  <= 1'b0;
            end else if (w_grant_b) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= b_addr_i;
                r_wr_d    <= b_data_i;
                r_last_b  <= 1'b1;
            end else begin
                r_wr_en <= 1'b0;
            end
        end
    end

    assign wr_en_o     = r_wr_en;
    assign wr_addr_o   = r_wr_addr;
    assign wr_d_o      = r_wr_d;
    assign fill_busy_o = r_busy;
    assign fill_done_o = r_done;

endmodule

// File: doc/fb_wr_sched.md
# fb_wr_sched

Write-port scheduler for the YUV422 framebuffer block RAM. It shares the single BRAM write port between two requesters, a host pixel writer (A) and a secondary writer (B) such as a test-pattern generator, using valid/ready handshakes and round-robin arbitration. It also contains a fill engine that overwrites every line with a constant word on command. The block sits directly in front of the framebuffer BRAM's write port. The BRAM read port is not touched.

## Interface
- LINES, 16, BRAM depth in words. Need not be a power of two. Minimum 2.
- DW, 32, BRAM word width.
- AW, $clog2(LINES), address width (derived; not to be overridden).

- clk_i  in  1  single clock for the whole block and the BRAM.
- rst_i  in  1  asynchronous, active-high reset.
- a_valid_i  in  1  requester A has a write pending.
- a_addr_i  in  AW  requester A write address.
- a_data_i  in  DW  requester A write data.
- a_ready_o  out  1  requester A write accepted this cycle when a_valid_i is high.
- b_valid_i / b_addr_i / b_data_i / b_ready_o: same as A, for requester B.
- fill_start_i  in  1  level-sampled request to start a fill.
- fill_data_i  in  DW  fill word. Captured on the edge that accepts fill_start_i.
- fill_busy_o  out  1  fill in progress.
- fill_done_o  out  1  one-cycle pulse when a fill completes.
- wr_addr_o  out  AW  to BRAM wr_addr_i.
- wr_d_o  out  DW  to BRAM wr_d_i.
- wr_en_o  out  1  to BRAM wr_en_i.

## Operation
- FSM has two states: ARB (reset state) and FILL.
- ARB:
  - If fill_start_i is high, go to FILL. a_ready_o and b_ready_o are low that cycle, so fill wins over both requesters.
  - Otherwise, grant at most one requester per cycle:
    - Only one valid: that requester is granted.
    - Both valid: grant the requester not granted most recently.
  - a_ready_o/b_ready_o are combinational and equal the grant.
  - The last-grant pointer updates only on an accepted handshake (valid && ready).
  - After reset, the pointer reads B, so A wins the first tie.
- A requester must hold valid, addr and data stable until ready. Dropping valid before ready is allowed; no write occurs.
- FILL:
  - An internal counter walks addresses 0 to LINES-1, one write per cycle, using the captured fill word.
  - After writing address LINES-1, return to ARB.
  - No addresses are skipped or repeated, and the counter never exceeds LINES-1, even when LINES is not a power of two.
  - Both readies stay low for the whole fill.
  - fill_start_i is ignored while in FILL. Changes to fill_data_i during a fill have no effect.
- wr_addr_o, wr_d_o and wr_en_o are registered, i.e. driven directly from flops.
- Reset, including mid-fill:
  - State returns to ARB and the pointer to B.
  - All outputs go to 0: wr_en_o, wr_addr_o, wr_d_o, fill_busy_o, fill_done_o.
  - a_ready_o/b_ready_o follow the ARB rules once rst_i deasserts.
  - An interrupted fill produces no fill_done_o.

## Timing
- Requester write:
  - Handshake on edge E means wr_en_o=1 with the handshake's addr/data during the cycle after E, for exactly one cycle.
  - Latency is 1 cycle. Throughput is 1 write per cycle with back-to-back grants.
- Fill accepted on edge E0:
  - wr_en_o=1 for exactly LINES consecutive cycles, starting the cycle after E0.
  - wr_addr_o is 0,1,…,LINES-1 and wr_d_o is the captured word throughout.
  - fill_busy_o is high during exactly those LINES cycles.
  - fill_done_o is high for one cycle, the cycle immediately after the last fill write.
  - Readies may assert in that same cycle, so a requester handshake there writes one cycle later, with no gap beyond that.
- Outside writes, wr_en_o=0. wr_addr_o/wr_d_o hold their last value; the BRAM ignores them.
- Simultaneous fill_start_i and requester valids in ARB: fill accepted, no requester handshake; requests stay pending until after the fill.

## Test plan
- Reset, then A valid with addr 3, data 0xDEADBEEF, held 1 cycle -> a_ready_o=1 same cycle; next cycle wr_en_o=1, wr_addr_o=3, wr_d_o=0xDEADBEEF; BRAM word 3 reads 0xDEADBEEF afterwards.
- A and B both valid continuously for 6 cycles -> grants A,B,A,B,A,B; wr_en_o high 6 consecutive cycles, each write matching the granted requester's addr/data.
- LINES=16, fill_start_i pulse with fill_data_i=0x00800080 -> 16 write cycles at addr 0..15, all 0x00800080; fill_busy_o high 16 cycles; fill_done_o pulses on cycle 17; readback of all 16 words equals 0x00800080.
- fill_start_i asserted in the same cycle as A valid -> a_ready_o=0 that cycle and throughout the fill; A's write issued the cycle after the fill_done_o cycle.
- LINES=10 fill -> exactly 10 writes at addr 0..9, no address ≥10 ever driven.
- rst_i asserted asynchronously after 5 fill writes -> wr_en_o and fill_busy_o drop immediately; no fill_done_o; after release, A handshake is accepted in the first cycle.
